// File: rtl/qtree_kron_sequencer.sv
// Sequencer feeding N_OPS operand streams, in order, into the mMapKron QTree input, then capturing the kernel result.
// Optional macro KRON_SEQ_WATCHDOG_EN adds a WAIT_RES timeout that sets the sticky error flag.
module qtree_kron_sequencer #(
  parameter int DATA_W  = 67,
  parameter int RES_W   = 33,
  parameter int N_OPS   = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CNT_W-1:0]        beat_cnt,
  output logic [RES_W-1:0]        result,
  input  logic [N_OPS*DATA_W-1:0] s_tdata,
  input  logic [N_OPS-1:0]        s_tvalid,
  input  logic [N_OPS-1:0]        s_tlast,
  output logic [N_OPS-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  input  logic [RES_W-1:0]        r_tdata,
  input  logic                    r_tvalid,
  output logic                    r_tready
);

  localparam int CUR_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [CUR_W-1:0] LAST_OP = CUR_W'(N_OPS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_DRAIN    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CUR_W-1:0]   cur_r, cur_s;
  logic               busy_r, done_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [RES_W-1:0]   result_r;
  logic [DATA_W-1:0]  m_tdata_r;
  logic               m_tvalid_r, m_tlast_r;
  logic               out_free_s, accept_s, take_res_s, job_start_s, timeout_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               sel_last_s;

  // The single output register may take a new beat when empty or emptying this cycle.
  assign out_free_s  = !m_tvalid_r || m_tready;
  assign sel_data_s  = s_tdata[int'(cur_r)*DATA_W +: DATA_W];
  assign sel_last_s  = s_tlast[cur_r];
  assign accept_s    = (state_r == S_FEED) && s_tvalid[cur_r] && out_free_s;
  assign take_res_s  = (state_r == S_WAIT_RES) && r_tvalid;
  assign job_start_s = (state_r == S_IDLE) && start;
  assign r_tready    = (state_r == S_WAIT_RES);

  for (genvar k = 0; k < N_OPS; k++) begin : g_ready
    assign s_tready[k] = (state_r == S_FEED) && (cur_r == CUR_W'(k)) && out_free_s;
  end

`ifdef KRON_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_r;
  logic            error_r;

  assign timeout_s = (state_r == S_WAIT_RES) && (wd_r == WD_W'(TIMEOUT - 1));

  // Watchdog cycle counter, cleared whenever the sequencer is outside WAIT_RES.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_r <= '0;
    end else if (state_r != S_WAIT_RES) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  // Sticky timeout flag; a genuine result in the timeout cycle wins.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      error_r <= 1'b0;
    end else if (job_start_s) begin
      error_r <= 1'b0;
    end else if (timeout_s && !r_tvalid) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  // Next-state and operand-pointer logic.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FEED;
          cur_s   = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FEED: begin
        if (accept_s && sel_last_s) begin
          if (cur_r == LAST_OP) begin
            state_s = S_DRAIN;
          end else begin
            cur_s = cur_r + CUR_W'(1);
          end
        end else begin
          state_s = S_FEED;
        end
      end
      S_DRAIN: begin
        if (out_free_s) begin
          state_s = S_WAIT_RES;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_WAIT_RES: begin
        if (r_tvalid) begin
          state_s = S_DONE;
        end else if (timeout_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT_RES;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        cur_s   = '0;
      end
    endcase
  end

  // Control state and status flags; busy/done are decoded from the next state so they are registered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= S_IDLE;
      cur_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      busy_r  <= (state_s == S_FEED) || (state_s == S_DRAIN) || (state_s == S_WAIT_RES);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Output stage register: loads on source handshake, empties on downstream handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_tdata_r  <= '0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (accept_s) begin
      m_tdata_r  <= sel_data_s;
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= sel_last_s;
    end else if (m_tready) begin
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  // Saturating count of beats accepted in the current job.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt_r <= '0;
    end else if (job_start_s) begin
      beat_cnt_r <= '0;
    end else if (accept_s && (beat_cnt_r != {CNT_W{1'b1}})) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Result capture; left untouched on timeout.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      result_r <= '0;
    end else if (take_res_s) begin
      result_r <= r_tdata;
    end else begin
      result_r <= result_r;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign beat_cnt = beat_cnt_r;
  assign result   = result_r;
  assign m_tdata  = m_tdata_r;
  assign m_tvalid = m_tvalid_r;
  assign m_tlast  = m_tlast_r;

endmodule

// File: tb/tb_qtree_kron_sequencer.sv
// Directed self-checking bench for qtree_kron_sequencer: two operands (3 + 2 beats), stalls, early result, mid-job reset, watchdog.
module tb_qtree_kron_sequencer;

  localparam int DATA_W = 67;
  localparam int RES_W  = 33;
  localparam int N_OPS  = 2;
  localparam int CNT_W  = 16;
`ifdef KRON_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  logic                    aclk = 1'b0;
  logic                    areset;
  logic                    start;
  logic                    busy, done, error;
  logic [CNT_W-1:0]        beat_cnt;
  logic [RES_W-1:0]        result;
  logic [N_OPS*DATA_W-1:0] s_tdata;
  logic [N_OPS-1:0]        s_tvalid, s_tlast, s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tvalid, m_tlast, m_tready;
  logic [RES_W-1:0]        r_tdata;
  logic                    r_tvalid, r_tready;

  qtree_kron_sequencer #(
    .DATA_W(DATA_W), .RES_W(RES_W), .N_OPS(N_OPS), .CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done), .error(error),
    .beat_cnt(beat_cnt), .result(result),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] op0 [3];
  logic [DATA_W-1:0] op1 [2];
  logic [DATA_W-1:0] exp_d [5];
  logic              exp_l [5];
  logic [DATA_W-1:0] junk;
  logic [RES_W-1:0]  last_result;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_error"},    error, 0);
    check({tag, "_beat_cnt"}, beat_cnt, 0);
    check({tag, "_result"},   result, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"},  m_tlast, 0);
    check({tag, "_m_tdata"},  m_tdata, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_r_tready"}, r_tready, 0);
  endtask

  // One complete job; operand1 is valid from the start and operand0 keeps offering junk after its tlast.
  task automatic run_job(input bit toggle, input bit early, input int res_delay,
                         input logic [RES_W-1:0] res_val, input logic [RES_W-1:0] exp_result,
                         input bit exp_err, input int exp_lat);
    int got = 0, idx0 = 0, idx1 = 0, done_cnt = 0, last_hs = 0;
    bit finished = 1'b0;
    logic stall_p = 1'b0, src_p = 1'b0;
    logic [DATA_W-1:0] stall_d = '0, src_d = '0, d0, d1;
    for (int st = 0; st < 120 && !finished; st++) begin
      @(negedge aclk);
      start    = (st == 0);
      m_tready = toggle ? (st % 2 == 0) : 1'b1;
      d0 = (idx0 < 3) ? op0[idx0] : junk;
      d1 = (idx1 < 2) ? op1[idx1] : junk;
      s_tdata  = {d1, d0};
      s_tvalid = {(idx1 < 2), 1'b1};
      s_tlast  = {(idx1 == 1), (idx0 == 2)};
      r_tvalid = early || ((got == 5) && ((st - last_hs) > res_delay));
      r_tdata  = res_val;
      #1;
      if (st == 1) begin
        check("busy_rise", busy, 1);
        check("error_clear", error, 0);
      end
      if (stall_p) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, stall_d);
      end
      if (src_p) begin
        check("lat_valid", m_tvalid, 1);
        check("lat_data", m_tdata, src_d);
      end
      if (idx0 < 3) check("op1_blocked", s_tready[1], 0);
      else          check("op0_ignored", s_tready[0], 0);
      if (got < 5) begin
        check("rready_low", r_tready, 0);
        check("result_hold", result, last_result);
      end
      if (done) begin
        done_cnt++;
        finished = 1'b1;
        check("done_busy_low", busy, 0);
        check("done_result", result, exp_result);
        check("done_error", error, exp_err);
        check("done_beat_cnt", beat_cnt, 5);
        check("done_beats", got, 5);
        check("done_latency", st - last_hs, exp_lat);
      end
      src_p = 1'b0;
      if (s_tvalid[0] && s_tready[0]) begin src_p = 1'b1; src_d = d0; idx0++; end
      if (s_tvalid[1] && s_tready[1]) begin src_p = 1'b1; src_d = d1; idx1++; end
      if (m_tvalid && m_tready) begin
        if (got < 5) begin
          check("m_data", m_tdata, exp_d[got]);
          check("m_last", m_tlast, exp_l[got]);
        end else begin
          check("extra_beat", got, 4);
        end
        got++;
        if (got == 5) last_hs = st;
      end
      stall_p = m_tvalid && !m_tready;
      stall_d = m_tdata;
    end
    if (!finished) check("done_timeout", finished, 1);
    @(negedge aclk);
    start = 1'b0; s_tvalid = '0; s_tlast = '0; r_tvalid = 1'b0; m_tready = 1'b1;
    #1;
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
    check("done_count", done_cnt, 1);
    last_result = exp_result;
  endtask

  initial begin
    op0[0] = 67'h4_0000_0000_0000_0A01;
    op0[1] = 67'h4_0000_0000_0000_0A02;
    op0[2] = 67'h4_0000_0000_0000_0A03;
    op1[0] = 67'h7_FFFF_0000_0000_0B01;
    op1[1] = 67'h7_FFFF_0000_0000_0B02;
    junk   = 67'h5_DEAD_BEEF_0000_0000;
    exp_d[0] = op0[0]; exp_d[1] = op0[1]; exp_d[2] = op0[2]; exp_d[3] = op1[0]; exp_d[4] = op1[1];
    exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b1; exp_l[3] = 1'b0; exp_l[4] = 1'b1;
    last_result = '0;

    areset = 1'b1; start = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    m_tready = 1'b1; r_tdata = '0; r_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_all_zero("reset");
    @(negedge aclk);
    areset = 1'b0;

    // Plain job, full throughput.
    run_job(1'b0, 1'b0, 0, 33'h1_0000_0005, 33'h1_0000_0005, 1'b0, 2);
    // Downstream ready toggling every cycle.
    run_job(1'b1, 1'b0, 0, 33'h0_1234_5678, 33'h0_1234_5678, 1'b0, 2);
    // Result presented from the very first cycle.
    run_job(1'b0, 1'b1, 0, 33'h1_ABCD_0001, 33'h1_ABCD_0001, 1'b0, 2);

    // Reset in the middle of operand0, after two accepted beats.
    @(negedge aclk);
    start = 1'b1; m_tready = 1'b1;
    s_tdata = {junk, op0[0]}; s_tvalid = 2'b01; s_tlast = 2'b00;
    @(negedge aclk);
    start = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    check("pre_reset_beat_cnt", beat_cnt, 2);
    check("pre_reset_busy", busy, 1);
    areset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge aclk);
    s_tvalid = '0;
    @(negedge aclk);
    areset = 1'b0;
    last_result = '0;
    run_job(1'b0, 1'b0, 0, 33'h0_0000_00AA, 33'h0_0000_00AA, 1'b0, 2);

`ifdef KRON_SEQ_WATCHDOG_EN
    // Result never arrives: timeout after TB_TIMEOUT cycles in WAIT_RES, result kept.
    run_job(1'b0, 1'b0, 100000, 33'h1_FFFF_FFFF, 33'h0_0000_00AA, 1'b1, TB_TIMEOUT + 1);
    check("error_sticky", error, 1);
    run_job(1'b0, 1'b0, 0, 33'h0_5555_0003, 33'h0_5555_0003, 1'b0, 2);
`else
    // Late result: sequencer waits without timing out.
    run_job(1'b0, 1'b0, 25, 33'h0_5555_0003, 33'h0_5555_0003, 1'b0, 27);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
